// File: rtl/mdr_mem_pkg.sv
// Shared types and defaults for the MDR-side memory access sequencer.
package mdr_mem_pkg;

  localparam int DEF_DW             = 16;
  localparam int DEF_AW             = 16;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic       {READ, WRITE}        op_e;

endpackage

// File: rtl/mdr_memory_interface.sv
// Memory access sequencer feeding the MDR input mux: one req/ack access at a time.
// Optional abort on a stalled memory is enabled with `define MEM_TIMEOUT_EN.
module mdr_memory_interface
  import mdr_mem_pkg::*;
#(
  parameter int DW             = DEF_DW,
  parameter int AW             = DEF_AW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [AW-1:0] mar_in,
  input  logic [DW-1:0] mdr_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] M_bus,
  output logic          MMD
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          timed_out;

`ifdef MEM_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef MEM_TIMEOUT_EN
    err_d      = 1'b0;
    wait_cnt_d = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        // Read has priority; a simultaneous write is simply dropped.
        if (rd_req) begin
          addr_d  = mar_in;
          op_d    = READ;
          state_d = ACCESS;
        end else if (wr_req) begin
          addr_d  = mar_in;
          wdata_d = mdr_in;
          op_d    = WRITE;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (op_q == READ) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
          // The counter reaches TIMEOUT_CYCLES on this cycle: give up.
          if (wait_cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_en_d = (state_d == ACCESS);
    mem_we_d = mem_en_d && (op_d == WRITE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign timed_out = err_q;
`else
  assign timed_out = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = timed_out;
  assign MMD       = done && (op_q == READ) && !timed_out;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign M_bus     = rdata_q;

endmodule

// File: tb/tb_mdr_memory_interface.sv
// Scoreboard bench for mdr_memory_interface: random accesses against a transaction-level model.
// Timeout scenario is exercised when MEM_TIMEOUT_EN is defined.
module tb_mdr_memory_interface;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req, wr_req;
  logic [AW-1:0] mar_in;
  logic [DW-1:0] mdr_in;
  logic          busy, done, err, mem_en, mem_we, mem_ack, MMD;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, M_bus;

  mdr_memory_interface #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req),
    .mar_in(mar_in), .mdr_in(mdr_in), .busy(busy), .done(done), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .M_bus(M_bus), .MMD(MMD)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] bus;
    bit            mmd;
    bit            err;
    int            cycles;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] last_read  = '0;
  logic [DW-1:0] last_wdata = '0;
  int            acc_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every memory-request cycle and every completion against the queue head.
  always @(negedge clk) begin
    if (!rst_n) acc_cycles = 0;
    if (mem_en) begin
      if (sb.size() == 0) check("mem_en_unexpected", 1, 0);
      else begin
        check("mem_we", mem_we, sb[0].we);
        check("mem_addr", mem_addr, sb[0].addr);
        check("mem_wdata", mem_wdata, sb[0].wdata);
        acc_cycles++;
      end
    end
    if (done) begin
      if (sb.size() == 0) check("done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("MMD", MMD, e.mmd);
        check("M_bus", M_bus, e.bus);
        check("err", err, e.err);
        check("access_cycles", acc_cycles, e.cycles);
      end
      acc_cycles = 0;
    end else if (MMD || err) begin
      check("strobe_without_done", {MMD, err}, 0);
    end
  end

  // Presents a command in IDLE and pushes the expected transaction. kind: 0 read, 1 write, 2 both.
  task automatic issue(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW-1:0] rdata, input int cycles, input bit timeout);
    exp_t e;
    rd_req = (kind != 1);
    wr_req = (kind != 0);
    mar_in = addr;
    mdr_in = data;
    e.addr   = addr;
    e.cycles = cycles;
    e.err    = timeout;
    if (kind == 1) begin
      last_wdata = data;
      e.we  = 1'b1;
      e.mmd = 1'b0;
    end else begin
      e.we  = 1'b0;
      e.mmd = !timeout;
      if (!timeout) last_read = rdata;
    end
    e.wdata = last_wdata;
    e.bus   = last_read;
    sb.push_back(e);
  endtask

  task automatic do_access(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW-1:0] rdata, input int waits, input bit busy_cmds);
    issue(kind, addr, data, rdata, waits + 1, 1'b0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    wr_req = busy_cmds;
    mar_in = AW'($urandom);
    mdr_in = DW'($urandom);
    for (int i = 0; i < waits; i++) begin
      mem_ack   = 1'b0;
      mem_rdata = DW'($urandom);
      @(posedge clk); #1;
      wr_req = 1'b0;
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = DW'($urandom);
    rd_req    = busy_cmds;
    wr_req    = busy_cmds;
    @(posedge clk); #1;
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mar_in = '0; mdr_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_err", err, 0);         check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);   check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_M_bus", M_bus, 0);     check("rst_MMD", MMD, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait read, then M_bus must hold the value.
    do_access(0, 16'h0040, 16'h5555, 16'hBEEF, 0, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("M_bus_hold", M_bus, 16'hBEEF);
    @(posedge clk); #1;

    // Three-wait write; read/write collision; commands while busy.
    do_access(1, 16'h0100, 16'h1234, 16'hDEAD, 3, 1'b0);
    do_access(2, 16'h0200, 16'h7777, 16'hA5A5, 1, 1'b0);
    do_access(1, 16'h0300, 16'h4321, 16'h0F0F, 2, 1'b1);
    do_access(0, 16'h0304, 16'h1111, 16'hC0DE, 0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        mem_ack   = 1'($urandom);
        mem_rdata = DW'($urandom);
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      do_access($urandom_range(0, 2), AW'($urandom), DW'($urandom), DW'($urandom),
                $urandom_range(0, 3), 1'($urandom));
    end

    // Reset during the second ACCESS cycle abandons the access.
    issue(0, 16'h0A0A, 16'h0, 16'h9999, 99, 1'b0);
    @(posedge clk); #1;
    rd_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    void'(sb.pop_back());
    last_read = '0;
    last_wdata = '0;
    @(negedge clk);
    check("rst_mid_mem_en", mem_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_M_bus", M_bus, 0);
    check("rst_mid_done_MMD", {done, MMD}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(0, 16'h0B0B, 16'h0, 16'h6161, 1, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // Stalled read aborts after TO ACCESS cycles with err and no MMD.
    issue(0, 16'h0C0C, 16'h0, 16'hFFFF, TO, 1'b1);
    @(posedge clk); #1;
    rd_req = 1'b0; mem_ack = 1'b0;
    repeat (TO) @(posedge clk);
    #1;
    @(posedge clk); #1;
    check("timeout_idle", busy, 0);
`else
    // Without the timeout the sequencer waits indefinitely.
    issue(0, 16'h0C0C, 16'h0, 16'h4242, 100, 1'b0);
    @(posedge clk); #1;
    rd_req = 1'b0; mem_ack = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("busy_100_cycles", busy_cnt, 100);
    mem_ack = 1'b1;
    mem_rdata = 16'h4242;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
